// File: rtl/ps2_line_controller_pkg.sv
// Shared definitions for the PS/2 command-line controller.
// Holds the default sizes, the prefix/control scan codes and the controller states.
package ps2_line_controller_pkg;

    localparam int DEF_MAX_CHARS = 32;
    localparam int DEF_LEN_W     = 6;
    localparam int DEF_ADDR_W    = 3;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/ps2_line_controller_if.sv
// Keyboard byte stream in, finished-line handshake and read port out.
// The master is the side that feeds bytes and consumes lines.
interface ps2_line_controller_if #(
    parameter int LEN_W  = 6,
    parameter int ADDR_W = 3
);
    logic [7:0]        ps2_info;
    logic              ps2_enable;
    logic              line_valid;
    logic [LEN_W-1:0]  line_len;
    logic              line_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic [31:0]       recent_chars;
    logic              overflow;

    modport master (
        output ps2_info, ps2_enable, line_ack, rd_addr,
        input  line_valid, line_len, rd_data, recent_chars, overflow
    );

    modport slave (
        input  ps2_info, ps2_enable, line_ack, rd_addr,
        output line_valid, line_len, rd_data, recent_chars, overflow
    );
endinterface

// File: rtl/ps2_line_controller_scancode_to_ascii.sv
// Set-2 make code to uppercase ASCII; 0x00 marks a code with no character.
module scancode_to_ascii (
    input  logic [7:0] scan_i,
    output logic [7:0] ascii_o
);
    always_comb begin
        ascii_o = 8'h00;
        case (scan_i)
            8'h1C: ascii_o = "A";  8'h32: ascii_o = "B";  8'h21: ascii_o = "C";
            8'h23: ascii_o = "D";  8'h24: ascii_o = "E";  8'h2B: ascii_o = "F";
            8'h34: ascii_o = "G";  8'h33: ascii_o = "H";  8'h43: ascii_o = "I";
            8'h3B: ascii_o = "J";  8'h42: ascii_o = "K";  8'h4B: ascii_o = "L";
            8'h3A: ascii_o = "M";  8'h31: ascii_o = "N";  8'h44: ascii_o = "O";
            8'h4D: ascii_o = "P";  8'h15: ascii_o = "Q";  8'h2D: ascii_o = "R";
            8'h1B: ascii_o = "S";  8'h2C: ascii_o = "T";  8'h3C: ascii_o = "U";
            8'h2A: ascii_o = "V";  8'h1D: ascii_o = "W";  8'h22: ascii_o = "X";
            8'h35: ascii_o = "Y";  8'h1A: ascii_o = "Z";
            8'h45: ascii_o = "0";  8'h16: ascii_o = "1";  8'h1E: ascii_o = "2";
            8'h26: ascii_o = "3";  8'h25: ascii_o = "4";  8'h2E: ascii_o = "5";
            8'h36: ascii_o = "6";  8'h3D: ascii_o = "7";  8'h3E: ascii_o = "8";
            8'h46: ascii_o = "9";  8'h29: ascii_o = " ";
            default: ascii_o = 8'h00;
        endcase
    end
endmodule

// File: rtl/ps2_line_controller.sv
// Collects PS/2 make codes into an editable line and hands it over on Enter.
// state        | meaning
// ST_COLLECT   | editing the line, no prefix pending
// ST_BREAK     | F0 seen, next byte is a released key and is discarded
// ST_EXT       | E0 seen, only keypad Enter or F0 matter
// ST_EXT_BREAK | E0 F0 seen, next byte is discarded
// ST_HOLD      | line complete, waiting for line_ack
module ps2_line_controller
    import ps2_line_controller_pkg::*;
#(
    parameter int MAX_CHARS = DEF_MAX_CHARS,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    ps2_line_controller_if.slave  bus
);
    localparam int               IDX_W = ADDR_W + 2;
    localparam logic [LEN_W-1:0] FULL  = LEN_W'(MAX_CHARS);

    state_e           state_q;
    logic [LEN_W-1:0] count_q;
    logic [7:0]       buf_q [MAX_CHARS];
    logic [31:0]      recent_q;
    logic [31:0]      rd_data_q;
    logic [31:0]      rd_data_d;
    logic             overflow_q;
    logic             line_valid_q;
    logic [7:0]       ascii;
    logic             char_wr;

    scancode_to_ascii u_xlat (
        .scan_i  (bus.ps2_info),
        .ascii_o (ascii)
    );

    assign char_wr = bus.ps2_enable && (state_q == ST_COLLECT) &&
                     (ascii != 8'h00) && (count_q != FULL);

    always_ff @(posedge clock) begin
        if (char_wr)
            buf_q[count_q[IDX_W-1:0]] <= ascii;
    end

    // Bytes at or beyond the current count read as zero so stale buffer data never leaks.
    always_comb begin
        rd_data_d = '0;
        for (int k = 0; k < 4; k++) begin
            if ({1'b0, bus.rd_addr, 2'(k)} < count_q)
                rd_data_d[31-8*k -: 8] = buf_q[{bus.rd_addr, 2'(k)}];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_COLLECT;
            count_q      <= '0;
            recent_q     <= '0;
            rd_data_q    <= '0;
            overflow_q   <= 1'b0;
            line_valid_q <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            case (state_q)
                ST_COLLECT: if (bus.ps2_enable) begin
                    if (bus.ps2_info == SC_BREAK) begin
                        state_q <= ST_BREAK;
                    end else if (bus.ps2_info == SC_EXT) begin
                        state_q <= ST_EXT;
                    end else if (bus.ps2_info == SC_ENTER) begin
                        state_q      <= ST_HOLD;
                        line_valid_q <= 1'b1;
                    end else if (bus.ps2_info == SC_BKSP) begin
                        if (count_q != '0) begin
                            count_q  <= count_q - 1'b1;
                            recent_q <= {8'h00, recent_q[31:8]};
                        end
                    end else if (char_wr) begin
                        count_q  <= count_q + 1'b1;
                        recent_q <= {recent_q[23:0], ascii};
                    end else if (ascii != 8'h00) begin
                        overflow_q <= 1'b1;
                    end
                end
                ST_BREAK, ST_EXT_BREAK: if (bus.ps2_enable) begin
                    state_q <= ST_COLLECT;
                end
                ST_EXT: if (bus.ps2_enable) begin
                    if (bus.ps2_info == SC_BREAK) begin
                        state_q <= ST_EXT_BREAK;
                    end else if (bus.ps2_info == SC_ENTER) begin
                        state_q      <= ST_HOLD;
                        line_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_COLLECT;
                    end
                end
                ST_HOLD: if (bus.line_ack) begin
                    state_q      <= ST_COLLECT;
                    line_valid_q <= 1'b0;
                    count_q      <= '0;
                    overflow_q   <= 1'b0;
                    recent_q     <= '0;
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    assign bus.line_valid   = line_valid_q;
    assign bus.line_len     = count_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.recent_chars = recent_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_ps2_line_controller.sv
// Randomised and directed stimulus for the PS/2 line controller, checked against
// a queue-based model of the typed line through an expectation scoreboard.
module tb_ps2_line_controller;

    localparam int K_LEN = 0, K_RECENT = 1, K_OVF = 2, K_VALID = 3, K_RD = 4;

    localparam logic [7:0] SC_TAB [37] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h29
    };
    string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789 ";

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ps2_line_controller_if #(.LEN_W(6), .ADDR_W(3)) bus ();

    ps2_line_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // reference model: the typed line, a four-deep echo window, and prefix flags
    logic [7:0] m_line[$];
    logic [7:0] m_win[$];
    bit         m_hold, m_skip, m_ext, m_ovf;

    item_t chk_q[$];
    int    enter_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  sample_req = 1'b0;
    logic  prev_valid = 1'b0;
    item_t it;
    logic [31:0] act;

    function automatic logic [7:0] ref_ascii(input logic [7:0] code);
        for (int i = 0; i < 37; i++)
            if (SC_TAB[i] == code) return chars[i];
        return 8'h00;
    endfunction

    function automatic logic [31:0] win_word();
        logic [31:0] v = '0;
        foreach (m_win[i]) v = {v[23:0], m_win[i]};
        return v;
    endfunction

    function automatic logic [31:0] line_word(input int addr);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            if (4*addr + k < m_line.size()) w[31-8*k -: 8] = m_line[4*addr + k];
        return w;
    endfunction

    task automatic model_clear();
        m_line.delete();
        m_win.delete();
        m_hold = 0; m_skip = 0; m_ext = 0; m_ovf = 0;
    endtask

    task automatic model_step(input logic [7:0] b);
        logic [7:0] a;
        a = ref_ascii(b);
        if (m_hold) return;
        if (m_skip) begin
            m_skip = 0;
        end else if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0) m_skip = 1;
            else if (b == 8'h5A) m_hold = 1;
        end else if (b == 8'hF0) begin
            m_skip = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'h5A) begin
            m_hold = 1;
        end else if (b == 8'h66) begin
            if (m_line.size() > 0) begin
                void'(m_line.pop_back());
                if (m_win.size() > 0) void'(m_win.pop_back());
            end
        end else if (a != 8'h00) begin
            if (m_line.size() < 32) begin
                m_line.push_back(a);
                m_win.push_back(a);
                if (m_win.size() > 4) void'(m_win.pop_front());
            end else begin
                m_ovf = 1;
            end
        end
        if (m_hold) enter_q.push_back(m_line.size());
    endtask

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // monitor: compares line_len when a line is presented, and queued items on sample strobes
    always @(negedge clock) begin
        if (bus.line_valid && !prev_valid) begin
            if (enter_q.size() == 0) compare("unexpected_line_valid", 32'd1, 32'd0);
            else compare("len_at_enter", 32'(bus.line_len), 32'(enter_q.pop_front()));
        end
        prev_valid = bus.line_valid;
        if (sample_req) begin
            while (chk_q.size() > 0) begin
                it = chk_q.pop_front();
                case (it.kind)
                    K_LEN:    act = 32'(bus.line_len);
                    K_RECENT: act = bus.recent_chars;
                    K_OVF:    act = 32'(bus.overflow);
                    K_VALID:  act = 32'(bus.line_valid);
                    default:  act = bus.rd_data;
                endcase
                compare(it.name, act, it.exp);
            end
        end
    end

    task automatic pulse_sample();
        sample_req = 1'b1;
        @(posedge clock); #1;
        sample_req = 1'b0;
    endtask

    task automatic checkpoint();
        chk_q.push_back('{K_LEN, 32'(m_line.size()), "line_len"});
        chk_q.push_back('{K_RECENT, win_word(), "recent_chars"});
        chk_q.push_back('{K_OVF, 32'(m_ovf), "overflow"});
        chk_q.push_back('{K_VALID, 32'(m_hold), "line_valid"});
        pulse_sample();
    endtask

    task automatic rd(input int addr);
        bus.rd_addr = 3'(addr);
        @(posedge clock); #1;
        chk_q.push_back('{K_RD, line_word(addr), $sformatf("rd_data[%0d]", addr)});
        pulse_sample();
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clock); #1;
        bus.ps2_info   = b;
        bus.ps2_enable = 1'b1;
        model_step(b);
        @(posedge clock); #1;
        bus.ps2_enable = 1'b0;
    endtask

    task automatic ack(input bit with_byte, input logic [7:0] b);
        @(posedge clock); #1;
        bus.line_ack = 1'b1;
        if (with_byte) begin
            bus.ps2_info   = b;
            bus.ps2_enable = 1'b1;
        end
        if (m_hold) model_clear();
        else if (with_byte) model_step(b);
        @(posedge clock); #1;
        bus.line_ack   = 1'b0;
        bus.ps2_enable = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic key(input logic [7:0] c);
        send(c); send(8'hF0); send(c);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) rd(a);
    endtask

    task automatic random_key();
        int r;
        logic [7:0] c;
        logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
        r = $urandom_range(0, 9);
        c = SC_TAB[$urandom_range(0, 36)];
        if (r <= 5) key(c);
        else if (r == 6) key(8'h66);
        else if (r == 7) begin
            c = arrows[$urandom_range(0, 3)];
            send(8'hE0); send(c); send(8'hE0); send(8'hF0); send(c);
        end else if (r == 8) begin
            c = 8'($urandom_range(0, 255));
            if (c == 8'hF0 || c == 8'hE0 || c == 8'h5A) c = 8'h0E;
            send(c);
        end else send(c);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        bus.ps2_info   = 8'h00;
        bus.ps2_enable = 1'b0;
        bus.line_ack   = 1'b0;
        bus.rd_addr    = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        checkpoint();
        chk_q.push_back('{K_RD, 32'h0, "rd_data_reset"});
        pulse_sample();
        reset = 1'b0;

        // two letters with their breaks, then Enter
        send(8'h2B); send(8'hF0); send(8'h2B);
        send(8'h23); send(8'hF0); send(8'h23);
        send(8'h5A);
        checkpoint(); rd(0); rd(1);
        ack(0, 8'h00); checkpoint();

        // backspace removes the newest character and its echo
        key(8'h1C); key(8'h16); key(8'h66);
        checkpoint();
        send(8'h5A); rd(0); checkpoint();
        ack(0, 8'h00);

        // arrow make/break is ignored; keypad Enter completes the line
        key(8'h45);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        checkpoint();
        send(8'hE0); send(8'h5A); checkpoint();
        ack(0, 8'h00); checkpoint();

        // fill past capacity
        for (int i = 0; i < 33; i++) send(SC_TAB[$urandom_range(0, 36)]);
        checkpoint();
        send(8'h5A); rd(7); checkpoint();
        ack(0, 8'h00); checkpoint();

        // bytes in HOLD are dropped, including one arriving with the ack
        key(8'h1C); send(8'h5A);
        send(8'h1C); send(8'h45); send(8'hF0); send(8'h5A);
        checkpoint(); rd(0);
        ack(1, 8'h45); checkpoint();
        send(8'h45); checkpoint();

        // stray ack in COLLECT is ignored, the simultaneous byte is accepted
        ack(1, 8'h1E); checkpoint();

        // reset right after a break prefix, then a make must not be eaten
        send(8'hF0); do_reset();
        send(8'h1C); checkpoint();

        // empty Enter
        do_reset(); send(8'h5A); checkpoint(); rd(0);
        ack(0, 8'h00);

        // reset while holding a line
        key(8'h24); send(8'h5A); do_reset(); checkpoint(); rd(0);

        for (int n = 0; n < 20; n++) begin
            int nk;
            nk = ($urandom_range(0, 4) == 0) ? 40 : $urandom_range(0, 12);
            for (int i = 0; i < nk; i++) random_key();
            checkpoint();
            if ($urandom_range(0, 1) == 1) send(8'h5A);
            else begin send(8'hE0); send(8'h5A); end
            send(8'hF0); send(8'h5A);
            checkpoint();
            read_all();
            for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)));
            checkpoint();
            ack($urandom_range(0, 1) == 1, SC_TAB[$urandom_range(0, 36)]);
            checkpoint();
        end

        repeat (3) @(posedge clock);
        #1;
        if (enter_q.size() != 0) compare("line_valid_never_rose", 32'd0, 32'(enter_q.size()));
        if (chk_q.size() != 0) compare("unsampled_items", 32'(chk_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
